alu_vector_checker: RTL

Synthesizable self-test sequencer placed directly upstream and downstream of `alu74181`. It reads packed 18-bit test vectors from a synchronous vector memory and drives the ALU's `s`, `M`, `ci`, `a` and `b` inputs. After a programmable settle time it compares the ALU's `y` against the expected nibble and accumulates pass/fail status. It brings the bench-only vector check into hardware for on-chip ALU self-test.

---
 rtl/alu_vec_pkg.sv | 21 ++
 rtl/alu_vector_checker_sat_counter.sv | 22 ++
 rtl/alu_vector_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_vec_pkg.sv
// Shared definitions for the ALU vector checker: packed vector layout and FSM states.
package alu_vec_pkg;

  localparam int VEC_W  = 18;
  localparam int S_LSB  = 14;
  localparam int M_BIT  = 13;
  localparam int CI_BIT = 12;
  localparam int A_LSB  = 8;
  localparam int B_LSB  = 4;
  localparam int Y_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } chk_state_t;

endpackage

// File: rtl/alu_vector_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/alu_vector_checker.sv
// On-chip ALU self-test: fetches packed vectors, drives the ALU, waits SETTLE
// cycles, compares y against the expected nibble and accumulates status.
module alu_vector_checker
  import alu_vec_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_vectors,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [VEC_W-1:0]  mem_data,
  output logic [3:0]        alu_s,
  output logic              alu_m,
  output logic              alu_ci,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  input  logic [3:0]        alu_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  vec_count,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [3:0]        fail_y
);

  chk_state_t        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   vec_total;
  logic [3:0]        settle_cnt;
  logic [3:0]        yexp;
  logic              first_seen;

  logic              start_ok;
  logic              in_check;
  logic              mismatch;
  logic              last_vec;
  logic [ADDR_W-1:0] idx_inc;

  assign start_ok = ((state == ST_IDLE) || (state == ST_DONE)) && start && !abort;
  assign in_check = (state == ST_CHECK) && !abort;
  // 4-state compare so an undriven or X result from the ALU counts as a failure
  assign mismatch = (alu_y !== yexp);
  assign idx_inc  = idx + ADDR_W'(1);
  assign last_vec = (({1'b0, idx} + (ADDR_W + 1)'(1)) == vec_total);

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (start_ok),
    .inc   (in_check && mismatch),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (start_ok),
    .inc   (in_check),
    .count (vec_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      vec_total  <= '0;
      settle_cnt <= '0;
      yexp       <= '0;
      first_seen <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      alu_s      <= '0;
      alu_m      <= 1'b0;
      alu_ci     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_idx   <= '0;
      fail_y     <= '0;
    end else if (abort) begin
      // Counters and ALU drive are deliberately left untouched for post-mortem
      state  <= ST_IDLE;
      mem_rd <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec_total  <= num_vectors;
            idx        <= '0;
            fail_idx   <= '0;
            fail_y     <= '0;
            first_seen <= 1'b0;
            if (num_vectors == '0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state    <= ST_FETCH;
              mem_rd   <= 1'b1;
              mem_addr <= '0;
              busy     <= 1'b1;
              done     <= 1'b0;
              pass     <= 1'b0;
            end
          end
        end
        ST_FETCH: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          alu_s      <= mem_data[S_LSB +: 4];
          alu_m      <= mem_data[M_BIT];
          alu_ci     <= mem_data[CI_BIT];
          alu_a      <= mem_data[A_LSB +: 4];
          alu_b      <= mem_data[B_LSB +: 4];
          yexp       <= mem_data[Y_LSB +: 4];
          settle_cnt <= 4'(SETTLE - 1);
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch && !first_seen) begin
            first_seen <= 1'b1;
            fail_idx   <= idx;
            fail_y     <= alu_y;
          end
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // err_count updates on this same edge, so fold in this vector's result
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            idx      <= idx_inc;
            mem_addr <= idx_inc;
            mem_rd   <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
